id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the RV32 integer core, directly upstream of the integer ALU.
- Latches decoded fields from ID and resolves operands with EX/MEM and MEM/WB forwarding.
- Drives the ALU's DATA1/DATA2/SELECT/ROTATE inputs and detects load-use hazards.
- Also holds under downstream back-pressure and inserts bubbles on flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
CLK  in  1  core clock, rising edge
RESETN  in  1  asynchronous active-low reset
ID_VALID  in  1  ID slot holds a real instruction
ID_PC  in  XLEN  instruction PC
ID_RS1_DATA / ID_RS2_DATA  in  XLEN  register-file read data
ID_RS1_ADDR / ID_RS2_ADDR / ID_RD_ADDR  in  RA_W  register indices
ID_USES_RS1 / ID_USES_RS2  in  1  instruction actually reads rs1/rs2
ID_IMM  in  XLEN  sign-extended immediate
ID_ALU_SELECT  in  3  ALU opcode (0 ADD … 7 AND)
ID_ROTATE  in  1  arithmetic-shift / subtype bit
ID_OP1_SEL  in  1  0 = rs1, 1 = PC
ID_OP2_SEL  in  1  0 = rs2, 1 = immediate
ID_REG_WRITE / ID_MEM_READ / ID_MEM_WRITE  in  1  control bits
EXMEM_REG_WRITE  in  1  EX/MEM writes rd
EXMEM_RD_ADDR  in  RA_W  EX/MEM destination
EXMEM_RESULT  in  XLEN  EX/MEM value
MEMWB_REG_WRITE  in  1  MEM/WB writes rd
MEMWB_RD_ADDR  in  RA_W  MEM/WB destination
MEMWB_RESULT  in  XLEN  MEM/WB value (ALU result or load data)
FLUSH  in  1  kill the instruction entering EX
MEM_BUSY  in  1  downstream cannot accept; EX must hold
DATA1 / DATA2  out  XLEN  ALU operands (combinational from registers + forwarding)
SELECT  out  3  ALU opcode
ROTATE  out  1  ALU subtype bit
EX_VALID  out  1  EX slot valid
EX_PC  out  XLEN  PC of EX instruction
EX_RD_ADDR  out  RA_W  destination
EX_REG_WRITE / EX_MEM_READ / EX_MEM_WRITE  out  1  control, gated by EX_VALID
EX_STORE_DATA  out  XLEN  forwarded rs2 for stores
STALL_ID  out  1  ID/IF must hold

Behaviour:
- Reset (RESETN=0, async): all registers cleared to 0, EX_VALID=0. With all registers 0, every output is 0.
- Forwarding, per operand r ∈ {rs1, rs2}, applied to registered data:
  - fwd_r = EXMEM_RESULT if EX_VALID && EXMEM_REG_WRITE && EXMEM_RD_ADDR==addr_r && addr_r!=0
  - else MEMWB_RESULT if EX_VALID && MEMWB_REG_WRITE && MEMWB_RD_ADDR==addr_r && addr_r!=0
  - else the registered data.
  - EX/MEM takes priority over MEM/WB. Register x0 never forwards.
- Operand outputs:
  - DATA1 = OP1_SEL ? PC : fwd_rs1.
  - DATA2 = OP2_SEL ? IMM : fwd_rs2.
  - EX_STORE_DATA = fwd_rs2.
- Load-use hazard (combinational):
  - hz = EX_VALID && EX_MEM_READ && EX_RD_ADDR!=0 && ID_VALID && ((ID_USES_RS1 && ID_RS1_ADDR==EX_RD_ADDR) || (ID_USES_RS2 && ID_RS2_ADDR==EX_RD_ADDR)).
- STALL_ID = MEM_BUSY || hz.
- Clock-edge priority:
  1. MEM_BUSY=1 → hold. All fields keep their values, except the rs1/rs2 data registers, which capture fwd_rs1/fwd_rs2. This prevents a forward being lost when MEM/WB retires during a multi-cycle hold. FLUSH is ignored while holding; upstream retains ownership of the flushed instruction.
  2. FLUSH=1 or hz=1 or ID_VALID=0 → bubble. EX_VALID=0 and all control and data fields cleared to 0.
  3. Otherwise → load all ID fields and set EX_VALID=1.
- Latency: one cycle from ID to the ALU inputs. A load-use hazard costs exactly one bubble; on the next cycle the load sits in MEM/WB and is forwarded.
- Simultaneous FLUSH and hz, with MEM_BUSY=0: a single bubble is inserted.
- Reset mid-hold: the slot is cleared immediately, independent of CLK.

Test Plan:
- Reset then ADD x3=x1+x2: ID_RS1_DATA=5, ID_RS2_DATA=7, SELECT=0 → next cycle DATA1=5, DATA2=7, SELECT=0, EX_VALID=1, EX_RD_ADDR=3.
- EX/MEM vs MEM/WB priority: EX rs1=4, EXMEM_RD=4/RESULT=0xAA, MEMWB_RD=4/RESULT=0xBB → DATA1=0xAA. Drop EXMEM_REG_WRITE → DATA1=0xBB. With rs1=0 and both sources targeting x0 → DATA1 = registered value.
- Load-use: lw x5 in EX, ID add uses x5 → STALL_ID=1 for one cycle, next EX_VALID=0. The following cycle, MEMWB_RESULT=0x1234 forwarded to DATA1.
- MEM_BUSY held 3 cycles while MEM/WB (x6=0x55) retires after cycle 1 → DATA2 stays 0x55 throughout; EX fields unchanged; STALL_ID=1.
- FLUSH=1 with ID_VALID=1 → next EX_VALID=0, EX_REG_WRITE=0, SELECT=0. FLUSH=1 with MEM_BUSY=1 → EX contents unchanged.
- Async reset asserted mid-cycle with EX_VALID=1 → EX_VALID=0 and DATA1=0 before the next CLK edge.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register of the RV32 integer core, sitting directly in front
// of the integer ALU. It latches the decoded fields from ID, resolves both
// source operands against the EX/MEM and MEM/WB result buses, drives the ALU
// operand/opcode inputs, and detects load-use hazards.
//
// Ports
//   CLK, RESETN              core clock (rising edge), async active-low reset
//   ID_*                     decoded instruction fields from the ID stage
//   EXMEM_* / MEMWB_*        destination/result of the two older instructions
//   FLUSH                    kill the instruction that would enter EX
//   MEM_BUSY                 downstream back-pressure; EX holds its contents
//   DATA1, DATA2             ALU operands (forwarded, combinational)
//   SELECT, ROTATE           ALU opcode and subtype bit
//   EX_*                     EX-slot sideband, control bits gated by EX_VALID
//   EX_STORE_DATA            forwarded rs2 value for stores
//   STALL_ID                 ID/IF must hold their instruction this cycle
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            CLK,
   input  logic            RESETN,
   input  logic            ID_VALID,
   input  logic [XLEN-1:0] ID_PC,
   input  logic [XLEN-1:0] ID_RS1_DATA,
   input  logic [XLEN-1:0] ID_RS2_DATA,
   input  logic [RA_W-1:0] ID_RS1_ADDR,
   input  logic [RA_W-1:0] ID_RS2_ADDR,
   input  logic [RA_W-1:0] ID_RD_ADDR,
   input  logic            ID_USES_RS1,
   input  logic            ID_USES_RS2,
   input  logic [XLEN-1:0] ID_IMM,
   input  logic [2:0]      ID_ALU_SELECT,
   input  logic            ID_ROTATE,
   input  logic            ID_OP1_SEL,
   input  logic            ID_OP2_SEL,
   input  logic            ID_REG_WRITE,
   input  logic            ID_MEM_READ,
   input  logic            ID_MEM_WRITE,
   input  logic            EXMEM_REG_WRITE,
   input  logic [RA_W-1:0] EXMEM_RD_ADDR,
   input  logic [XLEN-1:0] EXMEM_RESULT,
   input  logic            MEMWB_REG_WRITE,
   input  logic [RA_W-1:0] MEMWB_RD_ADDR,
   input  logic [XLEN-1:0] MEMWB_RESULT,
   input  logic            FLUSH,
   input  logic            MEM_BUSY,
   output logic [XLEN-1:0] DATA1,
   output logic [XLEN-1:0] DATA2,
   output logic [2:0]      SELECT,
   output logic            ROTATE,
   output logic            EX_VALID,
   output logic [XLEN-1:0] EX_PC,
   output logic [RA_W-1:0] EX_RD_ADDR,
   output logic            EX_REG_WRITE,
   output logic            EX_MEM_READ,
   output logic            EX_MEM_WRITE,
   output logic [XLEN-1:0] EX_STORE_DATA,
   output logic            STALL_ID
);

   // Everything the EX slot remembers about its instruction.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [RA_W-1:0] rs1_addr;
      logic [RA_W-1:0] rs2_addr;
      logic [RA_W-1:0] rd_addr;
      logic [XLEN-1:0] imm;
      logic [2:0]      alu_select;
      logic            rotate;
      logic            op1_sel;
      logic            op2_sel;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } ex_slot_t;

   ex_slot_t        slot_q, slot_d;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;
   logic            load_use_hz;

   // Operand forwarding. EX/MEM is the younger result so it wins over MEM/WB;
   // x0 is hard-wired zero and must never pick up a forwarded value.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no path leaves
      // it unassigned; that is what keeps latches from being inferred.
      fwd_rs1 = slot_q.rs1_data;
      fwd_rs2 = slot_q.rs2_data;

      if (slot_q.valid && (slot_q.rs1_addr != '0)) begin
         if (EXMEM_REG_WRITE && (EXMEM_RD_ADDR == slot_q.rs1_addr))
            fwd_rs1 = EXMEM_RESULT;
         else if (MEMWB_REG_WRITE && (MEMWB_RD_ADDR == slot_q.rs1_addr))
            fwd_rs1 = MEMWB_RESULT;
      end

      if (slot_q.valid && (slot_q.rs2_addr != '0)) begin
         if (EXMEM_REG_WRITE && (EXMEM_RD_ADDR == slot_q.rs2_addr))
            fwd_rs2 = EXMEM_RESULT;
         else if (MEMWB_REG_WRITE && (MEMWB_RD_ADDR == slot_q.rs2_addr))
            fwd_rs2 = MEMWB_RESULT;
      end
   end

   // A load in EX has no data until MEM completes, so a dependent instruction
   // in ID must wait one cycle and then pick the value up from MEM/WB.
   assign load_use_hz = slot_q.valid && slot_q.mem_read && (slot_q.rd_addr != '0) &&
                        ID_VALID &&
                        ((ID_USES_RS1 && (ID_RS1_ADDR == slot_q.rd_addr)) ||
                         (ID_USES_RS2 && (ID_RS2_ADDR == slot_q.rd_addr)));

   assign STALL_ID = MEM_BUSY || load_use_hz;

   // Next-state selection: hold > bubble > load.
   always_comb begin
      slot_d = slot_q;
      if (MEM_BUSY) begin
         // While held, the older instructions keep retiring. Capturing the
         // forwarded operands now means a MEM/WB value that leaves the bypass
         // network mid-hold is not lost. FLUSH is deliberately ignored here:
         // upstream still owns the flushed instruction.
         slot_d.rs1_data = fwd_rs1;
         slot_d.rs2_data = fwd_rs2;
      end else if (FLUSH || load_use_hz || !ID_VALID) begin
         slot_d = '0;
      end else begin
         slot_d.valid      = 1'b1;
         slot_d.pc         = ID_PC;
         slot_d.rs1_data   = ID_RS1_DATA;
         slot_d.rs2_data   = ID_RS2_DATA;
         slot_d.rs1_addr   = ID_RS1_ADDR;
         slot_d.rs2_addr   = ID_RS2_ADDR;
         slot_d.rd_addr    = ID_RD_ADDR;
         slot_d.imm        = ID_IMM;
         slot_d.alu_select = ID_ALU_SELECT;
         slot_d.rotate     = ID_ROTATE;
         slot_d.op1_sel    = ID_OP1_SEL;
         slot_d.op2_sel    = ID_OP2_SEL;
         slot_d.reg_write  = ID_REG_WRITE;
         slot_d.mem_read   = ID_MEM_READ;
         slot_d.mem_write  = ID_MEM_WRITE;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of evaluation order.
      if (!RESETN) slot_q <= '0;
      else         slot_q <= slot_d;
   end

   assign DATA1         = slot_q.op1_sel ? slot_q.pc  : fwd_rs1;
   assign DATA2         = slot_q.op2_sel ? slot_q.imm : fwd_rs2;
   assign EX_STORE_DATA = fwd_rs2;
   assign SELECT        = slot_q.alu_select;
   assign ROTATE        = slot_q.rotate;
   assign EX_VALID      = slot_q.valid;
   assign EX_PC         = slot_q.pc;
   assign EX_RD_ADDR    = slot_q.rd_addr;
   assign EX_REG_WRITE  = slot_q.valid && slot_q.reg_write;
   assign EX_MEM_READ   = slot_q.valid && slot_q.mem_read;
   assign EX_MEM_WRITE  = slot_q.valid && slot_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed scenarios for reset, basic ALU issue, forwarding priority,
// load-use stall, back-pressure hold, flush and async reset, followed by a
// randomized run checked against a behavioural model of the EX slot.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

   localparam int XLEN = 32;
   localparam int RA_W = 5;
   localparam int OUT_W = 4*XLEN + 3 + 1 + 1 + RA_W + 3 + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_valid;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic            id_uses_rs1, id_uses_rs2;
   logic [2:0]      id_alu_select;
   logic            id_rotate, id_op1_sel, id_op2_sel;
   logic            id_reg_write, id_mem_read, id_mem_write;
   logic            exmem_reg_write, memwb_reg_write;
   logic [RA_W-1:0] exmem_rd_addr, memwb_rd_addr;
   logic [XLEN-1:0] exmem_result, memwb_result;
   logic            flush, mem_busy;
   logic [XLEN-1:0] data1, data2, ex_pc, ex_store_data;
   logic [2:0]      select_o;
   logic            rotate_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_id;
   logic [RA_W-1:0] ex_rd_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .CLK(clk), .RESETN(rst_n),
      .ID_VALID(id_valid), .ID_PC(id_pc),
      .ID_RS1_DATA(id_rs1_data), .ID_RS2_DATA(id_rs2_data),
      .ID_RS1_ADDR(id_rs1_addr), .ID_RS2_ADDR(id_rs2_addr), .ID_RD_ADDR(id_rd_addr),
      .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
      .ID_IMM(id_imm), .ID_ALU_SELECT(id_alu_select), .ID_ROTATE(id_rotate),
      .ID_OP1_SEL(id_op1_sel), .ID_OP2_SEL(id_op2_sel),
      .ID_REG_WRITE(id_reg_write), .ID_MEM_READ(id_mem_read), .ID_MEM_WRITE(id_mem_write),
      .EXMEM_REG_WRITE(exmem_reg_write), .EXMEM_RD_ADDR(exmem_rd_addr), .EXMEM_RESULT(exmem_result),
      .MEMWB_REG_WRITE(memwb_reg_write), .MEMWB_RD_ADDR(memwb_rd_addr), .MEMWB_RESULT(memwb_result),
      .FLUSH(flush), .MEM_BUSY(mem_busy),
      .DATA1(data1), .DATA2(data2), .SELECT(select_o), .ROTATE(rotate_o),
      .EX_VALID(ex_valid), .EX_PC(ex_pc), .EX_RD_ADDR(ex_rd_addr),
      .EX_REG_WRITE(ex_reg_write), .EX_MEM_READ(ex_mem_read), .EX_MEM_WRITE(ex_mem_write),
      .EX_STORE_DATA(ex_store_data), .STALL_ID(stall_id)
   );

   // All observable outputs packed together for whole-interface comparison.
   wire [OUT_W-1:0] dut_out = {data1, data2, select_o, rotate_o, ex_valid, ex_pc, ex_rd_addr,
                               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall_id};

   // ---------------------------------------------------------------- helpers
   task automatic clear_inputs();
      id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_alu_select = 0; id_rotate = 0; id_op1_sel = 0; id_op2_sel = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
      flush = 0; mem_busy = 0;
   endtask

   // Register-register ALU op (or load when mr=1, which uses the immediate).
   task automatic drive_op(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1a,
                           input logic [XLEN-1:0] rs1d, input logic [RA_W-1:0] rs2a,
                           input logic [XLEN-1:0] rs2d, input logic [RA_W-1:0] rd,
                           input logic [2:0] sel, input logic mr);
      id_valid = 1; id_pc = pc;
      id_rs1_addr = rs1a; id_rs1_data = rs1d; id_uses_rs1 = 1;
      id_rs2_addr = rs2a; id_rs2_data = rs2d; id_uses_rs2 = !mr;
      id_rd_addr = rd; id_imm = 32'h4; id_alu_select = sel; id_rotate = 0;
      id_op1_sel = 0; id_op2_sel = mr; id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------- behavioural model
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
      logic [RA_W-1:0] rs1_addr, rs2_addr, rd;
      logic [2:0]      sel;
      logic            rot, op1, op2, rw, mr, mw;
   } slot_t;

   slot_t m;

   // Value an instruction sees for register 'addr' given its latched copy:
   // walk the in-flight producers from youngest to oldest.
   function automatic logic [XLEN-1:0] model_fwd(input logic [RA_W-1:0] addr,
                                                 input logic [XLEN-1:0] latched);
      logic            wr  [2];
      logic [RA_W-1:0] dst [2];
      logic [XLEN-1:0] val [2];
      wr[0] = exmem_reg_write; dst[0] = exmem_rd_addr; val[0] = exmem_result;
      wr[1] = memwb_reg_write; dst[1] = memwb_rd_addr; val[1] = memwb_result;
      if (!m.valid || addr == 0) return latched;
      for (int k = 0; k < 2; k++)
         if (wr[k] && dst[k] == addr) return val[k];
      return latched;
   endfunction

   function automatic logic model_hz();
      if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 1'b0;
      return (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
   endfunction

   function automatic logic [OUT_W-1:0] model_outputs();
      logic [XLEN-1:0] f1, f2;
      f1 = model_fwd(m.rs1_addr, m.rs1_data);
      f2 = model_fwd(m.rs2_addr, m.rs2_data);
      return {(m.op1 ? m.pc : f1), (m.op2 ? m.imm : f2), m.sel, m.rot, m.valid, m.pc, m.rd,
              m.valid & m.rw, m.valid & m.mr, m.valid & m.mw, f2, mem_busy | model_hz()};
   endfunction

   function automatic slot_t model_next();
      slot_t n;
      n = m;
      if (mem_busy) begin
         n.rs1_data = model_fwd(m.rs1_addr, m.rs1_data);
         n.rs2_data = model_fwd(m.rs2_addr, m.rs2_data);
      end else if (flush || !id_valid || model_hz()) begin
         n = '0;
      end else begin
         n = '{valid: 1'b1, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
               imm: id_imm, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr, rd: id_rd_addr,
               sel: id_alu_select, rot: id_rotate, op1: id_op1_sel, op2: id_op2_sel,
               rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
      end
      return n;
   endfunction

   // ------------------------------------------------------------- tests
   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #3;
      checks++;
      if (dut_out !== '0) begin
         failures++; $display("FAIL reset_outputs: got %h expected 0", dut_out);
      end
      @(negedge clk); @(negedge clk);
      checks++;
      if (ex_valid !== 1'b0) begin
         failures++; $display("FAIL reset_ex_valid_after_clk: got %b expected 0", ex_valid);
      end
      rst_n = 1;
      step();
   endtask

   task automatic test_add();
      clear_inputs();
      drive_op(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 3'd0, 1'b0);
      step();
      clear_inputs();
      #1;
      checks++;
      if ({data1, data2, select_o, ex_valid, ex_rd_addr, ex_reg_write, ex_pc} !==
          {32'd5, 32'd7, 3'd0, 1'b1, 5'd3, 1'b1, 32'h40}) begin
         failures++;
         $display("FAIL add_issue: got d1=%h d2=%h sel=%0d v=%b rd=%0d rw=%b pc=%h expected d1=5 d2=7 sel=0 v=1 rd=3 rw=1 pc=40",
                  data1, data2, select_o, ex_valid, ex_rd_addr, ex_reg_write, ex_pc);
      end
   endtask

   task automatic test_fwd_priority();
      clear_inputs();
      drive_op(32'h80, 5'd4, 32'h11, 5'd4, 32'h22, 5'd9, 3'd0, 1'b0);
      step();
      clear_inputs();
      exmem_reg_write = 1; exmem_rd_addr = 4; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd_addr = 4; memwb_result = 32'hBB;
      #1;
      checks++;
      if (data1 !== 32'hAA) begin
         failures++; $display("FAIL fwd_exmem_priority: got %h expected 000000aa", data1);
      end
      checks++;
      if (ex_store_data !== 32'hAA) begin
         failures++; $display("FAIL fwd_store_data: got %h expected 000000aa", ex_store_data);
      end
      exmem_reg_write = 0;
      #1;
      checks++;
      if (data1 !== 32'hBB) begin
         failures++; $display("FAIL fwd_memwb: got %h expected 000000bb", data1);
      end
      // x0 source: both producers target x0, latched value must survive.
      exmem_reg_write = 0; memwb_reg_write = 0;
      drive_op(32'h84, 5'd0, 32'h33, 5'd0, 32'h44, 5'd9, 3'd0, 1'b0);
      step();
      clear_inputs();
      exmem_reg_write = 1; exmem_rd_addr = 0; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd_addr = 0; memwb_result = 32'hBB;
      #1;
      checks++;
      if ({data1, data2} !== {32'h33, 32'h44}) begin
         failures++; $display("FAIL fwd_x0_blocked: got d1=%h d2=%h expected d1=33 d2=44", data1, data2);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_load_use();
      clear_inputs();
      drive_op(32'h100, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 3'd0, 1'b1);  // lw x5
      step();
      drive_op(32'h104, 5'd5, 32'hDEAD, 5'd2, 32'd3, 5'd7, 3'd0, 1'b0); // add x7,x5,x2
      #1;
      checks++;
      if (stall_id !== 1'b1) begin
         failures++; $display("FAIL load_use_stall: got %b expected 1", stall_id);
      end
      step();
      checks++;
      if ({ex_valid, stall_id, ex_reg_write} !== 3'b000) begin
         failures++; $display("FAIL load_use_bubble: got v=%b stall=%b rw=%b expected 0 0 0",
                              ex_valid, stall_id, ex_reg_write);
      end
      step();
      memwb_reg_write = 1; memwb_rd_addr = 5; memwb_result = 32'h1234;
      #1;
      checks++;
      if ({ex_valid, data1, data2} !== {1'b1, 32'h1234, 32'd3}) begin
         failures++; $display("FAIL load_use_forward: got v=%b d1=%h d2=%h expected v=1 d1=1234 d2=3",
                              ex_valid, data1, data2);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_mem_busy();
      clear_inputs();
      drive_op(32'h200, 5'd1, 32'h10, 5'd6, 32'h11, 5'd8, 3'd5, 1'b0);
      step();
      clear_inputs();
      mem_busy = 1;
      memwb_reg_write = 1; memwb_rd_addr = 6; memwb_result = 32'h55;
      #1;
      checks++;
      if ({data2, stall_id} !== {32'h55, 1'b1}) begin
         failures++; $display("FAIL busy_cycle0: got d2=%h stall=%b expected d2=55 stall=1", data2, stall_id);
      end
      step();
      // MEM/WB has retired; ID now offers something else plus a flush.
      memwb_reg_write = 0; memwb_result = 32'h99;
      drive_op(32'h300, 5'd2, 32'h77, 5'd3, 32'h66, 5'd12, 3'd2, 1'b0);
      flush = 1;
      for (int c = 1; c <= 3; c++) begin
         #1;
         checks++;
         if ({data2, ex_valid, ex_rd_addr, select_o, ex_pc, stall_id} !==
             {32'h55, 1'b1, 5'd8, 3'd5, 32'h200, 1'b1}) begin
            failures++;
            $display("FAIL busy_hold_c%0d: got d2=%h v=%b rd=%0d sel=%0d pc=%h stall=%b expected d2=55 v=1 rd=8 sel=5 pc=200 stall=1",
                     c, data2, ex_valid, ex_rd_addr, select_o, ex_pc, stall_id);
         end
         if (c < 3) step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_flush();
      clear_inputs();
      drive_op(32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 3'd3, 1'b0);
      flush = 1;
      step();
      checks++;
      if ({ex_valid, ex_reg_write, select_o, data1} !== '0) begin
         failures++; $display("FAIL flush_bubble: got v=%b rw=%b sel=%0d d1=%h expected all 0",
                              ex_valid, ex_reg_write, select_o, data1);
      end
      // FLUSH together with a load-use hazard inserts only one bubble.
      clear_inputs();
      drive_op(32'h500, 5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 3'd0, 1'b1);
      step();
      drive_op(32'h504, 5'd5, 32'h1, 5'd2, 32'h2, 5'd7, 3'd0, 1'b0);
      flush = 1;
      step();
      checks++;
      if (ex_valid !== 1'b0) begin
         failures++; $display("FAIL flush_hz_bubble: got %b expected 0", ex_valid);
      end
      flush = 0;
      step();
      checks++;
      if ({ex_valid, ex_rd_addr} !== {1'b1, 5'd7}) begin
         failures++; $display("FAIL flush_hz_single: got v=%b rd=%0d expected v=1 rd=7", ex_valid, ex_rd_addr);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_async_reset();
      clear_inputs();
      drive_op(32'h600, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 3'd1, 1'b0);
      step();
      clear_inputs();
      mem_busy = 1;
      #1;
      checks++;
      if ({ex_valid, data1} !== {1'b1, 32'd5}) begin
         failures++; $display("FAIL async_pre: got v=%b d1=%h expected v=1 d1=5", ex_valid, data1);
      end
      rst_n = 0;
      #1;  // well before the next rising edge
      checks++;
      if ({ex_valid, data1} !== '0) begin
         failures++; $display("FAIL async_reset_clear: got v=%b d1=%h expected 0 0", ex_valid, data1);
      end
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      step();
   endtask

   task automatic test_random();
      int errs_here;
      slot_t nxt;
      clear_inputs();
      step();
      m = '0;
      errs_here = 0;
      for (int c = 0; c < 400; c++) begin
         id_valid        = ($urandom_range(0, 3) != 0);
         id_pc           = $urandom; id_imm = $urandom;
         id_rs1_data     = $urandom; id_rs2_data = $urandom;
         id_rs1_addr     = RA_W'($urandom_range(0, 7));
         id_rs2_addr     = RA_W'($urandom_range(0, 7));
         id_rd_addr      = RA_W'($urandom_range(0, 7));
         id_uses_rs1     = 1'($urandom); id_uses_rs2 = 1'($urandom);
         id_alu_select   = 3'($urandom); id_rotate = 1'($urandom);
         id_op1_sel      = 1'($urandom); id_op2_sel = 1'($urandom);
         id_reg_write    = 1'($urandom);
         id_mem_read     = ($urandom_range(0, 2) == 0);
         id_mem_write    = 1'($urandom);
         exmem_reg_write = 1'($urandom); exmem_rd_addr = RA_W'($urandom_range(0, 7));
         exmem_result    = $urandom;
         memwb_reg_write = 1'($urandom); memwb_rd_addr = RA_W'($urandom_range(0, 7));
         memwb_result    = $urandom;
         flush           = ($urandom_range(0, 7) == 0);
         mem_busy        = ($urandom_range(0, 3) == 0);
         #1;
         checks++;
         if (dut_out !== model_outputs()) begin
            failures++; errs_here++;
            if (errs_here <= 10)
               $display("FAIL random_c%0d: got %h expected %h", c, dut_out, model_outputs());
         end
         nxt = model_next();
         @(posedge clk);
         m = nxt;
         #1;
      end
      clear_inputs();
      step();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_add();
      test_fwd_priority();
      test_load_use();
      test_mem_busy();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net: the sequence above is bounded, but never let the run hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
